match_sequencer: RTL and testbench
==================================

Name: match_sequencer

Overview:
Top-level game-flow controller for Pong. It sequences the game logic through idle, serve, play, pause, point and game-over phases, and keeps both players' scores. It gates game logic with a run enable, requests ball re-centering, and selects serve direction. It sits between the board keys and the game logic, with scores and winner exported to display blocks.

Parameters:
PAUSE_CYCLES, 50000000, length in clk cycles of each SERVE and POINT phase (must be >= 1)
WIN_SCORE, 11, score that ends the match (1..127)

Ports:
clk          in   1  system clock (50 MHz domain)
rst_n        in   1  asynchronous active-low reset
start        in   1  one-cycle pulse, begin or restart a match
pause        in   1  one-cycle pulse, toggle pause during play
point_left   in   1  one-cycle pulse, left player scored
point_right  in   1  one-cycle pulse, right player scored
logic_run    out  1  high while game logic may move ball/paddles
ball_reset   out  1  one-cycle pulse, re-centre ball
serve_dir    out  1  0 = serve toward left, 1 = serve toward right
score_left   out  7  left score, binary
score_right  out  7  right score, binary
game_over    out  1  high while in OVER
winner       out  1  0 = left won, 1 = right won; valid when game_over
state        out  3  IDLE=0 SERVE=1 PLAY=2 PAUSED=3 POINT=4 OVER=5

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE, timer=0, and all outputs 0. This applies immediately, including mid-phase.
- Outputs are registered. logic_run = (state==PLAY); game_over = (state==OVER).
- Timer: down-counter, width $clog2(PAUSE_CYCLES+1). It loads PAUSE_CYCLES-1 on entry to SERVE or POINT. The phase exits on the edge where timer==0, so each phase lasts exactly PAUSE_CYCLES cycles.
- IDLE: start -> SERVE. Scores are cleared to 0 and serve_dir is set to 0.
- SERVE: ball_reset is high for exactly the first cycle of SERVE. On timer==0 -> PLAY.
- PLAY:
  - point_left -> score_left+1 and serve_dir=1 (serve toward the conceding player).
  - point_right -> score_right+1 and serve_dir=0.
  - Both point pulses in the same cycle: point_left wins and point_right is dropped.
  - If the incremented score == WIN_SCORE -> OVER, winner = scorer. Otherwise -> POINT.
  - pause with no point -> PAUSED. A point pulse takes priority over pause in the same cycle.
- PAUSED: logic_run=0. pause -> PLAY. point_left and point_right are ignored.
- POINT: logic_run=0. On timer==0 -> SERVE, which produces the ball_reset pulse.
- OVER: scores and winner are held. start -> SERVE with scores cleared and serve_dir=0.
- Ignored inputs:
  - start is ignored in SERVE, PLAY, PAUSED and POINT.
  - pause is ignored outside PLAY and PAUSED.
  - point pulses are ignored outside PLAY.
- Score timing: a score update is visible the cycle after the point pulse is sampled, i.e. the first cycle of POINT or OVER.
- Score width: scores never exceed WIN_SCORE, so no wrap is possible.
- Point-to-play latency: after a point pulse sampled at edge k, logic_run is low for exactly 2*PAUSE_CYCLES cycles. It returns high at edge k+2*PAUSE_CYCLES.
- Start-to-play latency: from a start pulse at edge k, logic_run rises at edge k+PAUSE_CYCLES.
- No combinational path from any input to any output.

Test Plan:
1. Reset then start pulse (PAUSE_CYCLES=4, WIN_SCORE=3) -> state goes 0->1, ball_reset high for exactly 1 cycle, logic_run rises 4 cycles after entering SERVE, scores stay 0.
2. point_left in PLAY -> score_left=1 on the next cycle, state=4, serve_dir=1. logic_run is low for 8 cycles, and ball_reset pulses once at the POINT->SERVE transition.
3. point_left and point_right in the same cycle while in PLAY -> score_left increments, score_right unchanged, serve_dir=1.
4. Right scores 3 times -> state=5, game_over=1, winner=1, score_right=3. Further point and pause pulses change nothing. A start pulse then clears scores to 0, sets state=1 and pulses ball_reset.
5. pause pulse in PLAY -> state=3 and logic_run=0. A point_right pulse while PAUSED is ignored (score unchanged). A second pause pulse returns state to 2. A pause pulse during SERVE is ignored.
6. Drive rst_n low mid-POINT, between clock edges -> state=0 and all outputs 0 immediately. After release, point pulses have no effect until start.

Source files
------------

// File: rtl/match_sequencer.sv
// match_sequencer: Pong game-flow controller.
// Sequences IDLE -> SERVE -> PLAY <-> PAUSED, PLAY -> POINT -> SERVE, PLAY -> OVER,
// keeps both scores and drives the game-logic run enable and ball re-centre pulse.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start, pause                    one-cycle key pulses
//   point_left, point_right         one-cycle scoring pulses from game logic
//   logic_run, ball_reset           game-logic enable, ball re-centre pulse
//   serve_dir                       0 = serve toward left, 1 = toward right
//   score_left, score_right         binary scores
//   game_over, winner               match finished, 0 = left won / 1 = right won
//   state                           IDLE=0 SERVE=1 PLAY=2 PAUSED=3 POINT=4 OVER=5
module match_sequencer #(
  parameter int unsigned PAUSE_CYCLES = 50000000,
  parameter int unsigned WIN_SCORE    = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       point_left,
  input  logic       point_right,
  output logic       logic_run,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [6:0] score_left,
  output logic [6:0] score_right,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  localparam int unsigned TW = $clog2(PAUSE_CYCLES + 1);
  localparam int unsigned SW = 7;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(PAUSE_CYCLES - 1);
  localparam logic [SW-1:0] WIN        = SW'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SERVE  = 3'd1,
    S_PLAY   = 3'd2,
    S_PAUSED = 3'd3,
    S_POINT  = 3'd4,
    S_OVER   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] score_left_d, score_right_d;
  logic [SW-1:0] inc_left, inc_right;
  logic          serve_dir_d, winner_d;
  logic          logic_run_d, ball_reset_d, game_over_d;

  assign state = state_q;

  // State, timer and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      score_left  <= '0;
      score_right <= '0;
      serve_dir   <= 1'b0;
      winner      <= 1'b0;
      logic_run   <= 1'b0;
      ball_reset  <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      score_left  <= score_left_d;
      score_right <= score_right_d;
      serve_dir   <= serve_dir_d;
      winner      <= winner_d;
      logic_run   <= logic_run_d;
      ball_reset  <= ball_reset_d;
      game_over   <= game_over_d;
    end
  end

  // Next-state, scoring and output decode
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    score_left_d  = score_left;
    score_right_d = score_right;
    serve_dir_d   = serve_dir;
    winner_d      = winner;
    inc_left      = score_left + SW'(1);
    inc_right     = score_right + SW'(1);

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d       = S_SERVE;
          timer_d       = TIMER_LOAD;
          score_left_d  = '0;
          score_right_d = '0;
          serve_dir_d   = 1'b0;
        end
      end
      S_SERVE: begin
        if (timer_q == '0) state_d = S_PLAY;
        else               timer_d = timer_q - TW'(1);
      end
      S_PLAY: begin
        // Left point outranks a simultaneous right point; any point outranks pause
        if (point_left) begin
          score_left_d = inc_left;
          serve_dir_d  = 1'b1;
          if (inc_left == WIN) begin
            state_d  = S_OVER;
            winner_d = 1'b0;
          end else begin
            state_d = S_POINT;
            timer_d = TIMER_LOAD;
          end
        end else if (point_right) begin
          score_right_d = inc_right;
          serve_dir_d   = 1'b0;
          if (inc_right == WIN) begin
            state_d  = S_OVER;
            winner_d = 1'b1;
          end else begin
            state_d = S_POINT;
            timer_d = TIMER_LOAD;
          end
        end else if (pause) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (pause) state_d = S_PLAY;
      end
      S_POINT: begin
        if (timer_q == '0) begin
          state_d = S_SERVE;
          timer_d = TIMER_LOAD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registers track the state they accompany
    logic_run_d  = (state_d == S_PLAY);
    game_over_d  = (state_d == S_OVER);
    ball_reset_d = (state_d == S_SERVE) && (state_q != S_SERVE);
  end

endmodule

// File: tb/tb_match_sequencer.sv
// tb_match_sequencer: directed scenarios plus randomized pulses against a phase/elapsed-time model.
module tb_match_sequencer;
  localparam int unsigned P   = 4;
  localparam int unsigned WIN = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, pause = 1'b0, point_left = 1'b0, point_right = 1'b0;
  logic       logic_run, ball_reset, serve_dir, game_over, winner;
  logic [6:0] score_left, score_right;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  // Reference model: phase number plus cycles elapsed in the current timed phase
  int m_phase, m_elapsed, m_sl, m_sr, m_dir, m_win, m_br;

  match_sequencer #(.PAUSE_CYCLES(P), .WIN_SCORE(WIN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
    .point_left(point_left), .point_right(point_right),
    .logic_run(logic_run), .ball_reset(ball_reset), .serve_dir(serve_dir),
    .score_left(score_left), .score_right(score_right),
    .game_over(game_over), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic model_reset;
    m_phase = 0; m_elapsed = 0; m_sl = 0; m_sr = 0; m_dir = 0; m_win = 0; m_br = 0;
  endtask

  task automatic model_step(input bit st, input bit pa, input bit pl, input bit pr);
    m_br = 0;
    case (m_phase)
      0, 5: if (st) begin
        m_phase = 1; m_elapsed = 0; m_br = 1; m_sl = 0; m_sr = 0; m_dir = 0;
      end
      1: begin
        m_elapsed++;
        if (m_elapsed == P) m_phase = 2;
      end
      2: begin
        if (pl) begin
          m_sl++; m_dir = 1;
          if (m_sl == WIN) begin m_phase = 5; m_win = 0; end
          else begin m_phase = 4; m_elapsed = 0; end
        end else if (pr) begin
          m_sr++; m_dir = 0;
          if (m_sr == WIN) begin m_phase = 5; m_win = 1; end
          else begin m_phase = 4; m_elapsed = 0; end
        end else if (pa) m_phase = 3;
      end
      3: if (pa) m_phase = 2;
      4: begin
        m_elapsed++;
        if (m_elapsed == P) begin m_phase = 1; m_elapsed = 0; m_br = 1; end
      end
      default: m_phase = 0;
    endcase
  endtask

  // One clock cycle with the given pulses; returns #1 after the active edge with inputs idle
  task automatic cyc(input bit st, input bit pa, input bit pl, input bit pr);
    start = st; pause = pa; point_left = pl; point_right = pr;
    @(posedge clk);
    model_step(st, pa, pl, pr);
    #1;
    start = 1'b0; pause = 1'b0; point_left = 1'b0; point_right = 1'b0;
  endtask

  task automatic wait_play;
    for (int i = 0; i < 4 * P && m_phase != 2; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    model_reset();
    #3;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", state); end
    checks++; if ({logic_run, ball_reset, serve_dir, game_over, winner} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b want=00000", {logic_run, ball_reset, serve_dir, game_over, winner}); end
    checks++; if (score_left !== 7'd0 || score_right !== 7'd0) begin
      failures++; $display("FAIL reset_scores got=%0d/%0d want=0/0", score_left, score_right); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_start;
    cyc(1, 0, 0, 0);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL start_state got=%0d want=1", state); end
    checks++; if (ball_reset !== 1'b1) begin failures++; $display("FAIL start_ball_reset got=%b want=1", ball_reset); end
    for (int i = 1; i <= int'(P); i++) begin
      cyc(0, 0, 0, 0);
      checks++; if (logic_run !== 1'(i >= int'(P))) begin
        failures++; $display("FAIL start_logic_run cycle=%0d got=%b want=%b", i, logic_run, i >= int'(P)); end
      checks++; if (ball_reset !== 1'b0) begin failures++; $display("FAIL start_ball_reset_width cycle=%0d got=%b want=0", i, ball_reset); end
    end
    checks++; if (score_left !== 7'd0 || score_right !== 7'd0) begin
      failures++; $display("FAIL start_scores got=%0d/%0d want=0/0", score_left, score_right); end
  endtask

  task automatic test_point;
    int n, pulses;
    cyc(0, 0, 1, 0);
    checks++; if (score_left !== 7'd1) begin failures++; $display("FAIL point_score got=%0d want=1", score_left); end
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL point_state got=%0d want=4", state); end
    checks++; if (serve_dir !== 1'b1) begin failures++; $display("FAIL point_dir got=%b want=1", serve_dir); end
    n = 0; pulses = 0;
    for (int i = 0; i < 4 * int'(P); i++) begin
      cyc(0, 0, 0, 0);
      n++;
      if (ball_reset === 1'b1) pulses++;
      if (logic_run === 1'b1) break;
    end
    checks++; if (n != 2 * int'(P)) begin failures++; $display("FAIL point_latency got=%0d want=%0d", n, 2 * P); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL point_ball_reset_count got=%0d want=1", pulses); end
  endtask

  task automatic test_both_points;
    cyc(0, 0, 1, 1);
    checks++; if (score_left !== 7'd2) begin failures++; $display("FAIL both_left got=%0d want=2", score_left); end
    checks++; if (score_right !== 7'd0) begin failures++; $display("FAIL both_right got=%0d want=0", score_right); end
    checks++; if (serve_dir !== 1'b1) begin failures++; $display("FAIL both_dir got=%b want=1", serve_dir); end
    wait_play();
  endtask

  task automatic test_game_over;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1);
      if (i < 2) wait_play();
    end
    checks++; if (state !== 3'd5) begin failures++; $display("FAIL over_state got=%0d want=5", state); end
    checks++; if (game_over !== 1'b1 || winner !== 1'b1) begin
      failures++; $display("FAIL over_flags got=%b%b want=11", game_over, winner); end
    checks++; if (score_right !== 7'd3 || score_left !== 7'd2) begin
      failures++; $display("FAIL over_scores got=%0d/%0d want=2/3", score_left, score_right); end
    cyc(0, 1, 1, 0); cyc(0, 0, 0, 1); cyc(0, 1, 1, 1);
    checks++; if (state !== 3'd5 || score_left !== 7'd2 || score_right !== 7'd3 || winner !== 1'b1) begin
      failures++; $display("FAIL over_hold got=%0d %0d/%0d w%b want=5 2/3 w1", state, score_left, score_right, winner); end
    cyc(1, 0, 0, 0);
    checks++; if (state !== 3'd1 || ball_reset !== 1'b1 || game_over !== 1'b0) begin
      failures++; $display("FAIL restart got=%0d br%b go%b want=1 br1 go0", state, ball_reset, game_over); end
    checks++; if (score_left !== 7'd0 || score_right !== 7'd0 || serve_dir !== 1'b0) begin
      failures++; $display("FAIL restart_clear got=%0d/%0d d%b want=0/0 d0", score_left, score_right, serve_dir); end
  endtask

  task automatic test_pause;
    cyc(0, 1, 0, 0);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL pause_in_serve got=%0d want=1", state); end
    wait_play();
    cyc(0, 1, 0, 0);
    checks++; if (state !== 3'd3 || logic_run !== 1'b0) begin
      failures++; $display("FAIL pause_enter got=%0d run%b want=3 run0", state, logic_run); end
    cyc(0, 0, 0, 1);
    checks++; if (state !== 3'd3 || score_right !== 7'd0) begin
      failures++; $display("FAIL paused_point got=%0d sr=%0d want=3 sr=0", state, score_right); end
    cyc(0, 1, 0, 0);
    checks++; if (state !== 3'd2 || logic_run !== 1'b1) begin
      failures++; $display("FAIL pause_exit got=%0d run%b want=2 run1", state, logic_run); end
  endtask

  task automatic test_async_reset;
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if ({state, logic_run, ball_reset, serve_dir, score_left, score_right, game_over, winner} !== 22'd0) begin
      failures++; $display("FAIL async_reset got=%0d run%b br%b %0d/%0d", state, logic_run, ball_reset, score_left, score_right); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 1, 1); cyc(0, 1, 1, 0); cyc(0, 0, 0, 1);
    checks++; if (state !== 3'd0 || score_left !== 7'd0 || score_right !== 7'd0) begin
      failures++; $display("FAIL idle_points got=%0d %0d/%0d want=0 0/0", state, score_left, score_right); end
    cyc(1, 0, 0, 0);
    checks++; if (state !== 3'd1 || ball_reset !== 1'b1) begin
      failures++; $display("FAIL post_reset_start got=%0d br%b want=1 br1", state, ball_reset); end
  endtask

  task automatic test_random;
    logic [21:0] got, exp;
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      got = {state, logic_run, ball_reset, serve_dir, score_left, score_right, game_over, winner};
      exp = {3'(m_phase), m_phase == 2, 1'(m_br), 1'(m_dir), 7'(m_sl), 7'(m_sr), m_phase == 5, 1'(m_win)};
      checks++; if (got !== exp) begin
        failures++; $display("FAIL random cycle=%0d got=%h want=%h", i, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_point();
    test_both_points();
    test_game_over();
    test_pause();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
